// File: rtl/q50_pkg.sv
// Shared definitions for the q50 pulse-train generator.
//   q50_gen_state_t : FSM state encoding (3 bits, IDLE = 0)
//   Q50_W           : default width of the gap fields and gap counter
//   Q50_PULSES      : number of x pulses in one complete train
//   is_pulse_state  : true for the states in which x is driven high
package q50_pkg;

    localparam int Q50_W      = 8;
    localparam int Q50_PULSES = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        P_ARM   = 3'd1,
        G_ARM   = 3'd2,
        P_OPEN  = 3'd3,
        G_A     = 3'd4,
        P_MID   = 3'd5,
        G_B     = 3'd6,
        P_CLOSE = 3'd7
    } q50_gen_state_t;

    function automatic logic is_pulse_state(input q50_gen_state_t s);
        return (s == P_ARM) || (s == P_OPEN) || (s == P_MID) || (s == P_CLOSE);
    endfunction

endpackage

// File: rtl/q50_gap_counter.sv
// Loadable W-bit down-counter that times the low gaps between pulses.
//   clk, rst  : clock, synchronous active-high reset (count -> 0)
//   load      : load load_val (takes priority over en)
//   load_val  : value to load, equal to the gap length in cycles
//   en        : decrement by one per cycle while count > 1
//   last      : count == 1, i.e. this is the final cycle of the gap
module q50_gap_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         last
);

    logic [W-1:0] count;

    // The count holds at 1 instead of stepping to 0: the gap state exits
    // on last, so the counter never needs to go lower and cannot wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count > W'(1))) begin
            count <= count - W'(1);
        end
    end

    assign last = (count == W'(1));

endmodule

// File: rtl/q50_pulse_gen.sv
// Pulse-train generator driving the x input of the three-state Moore pulse
// detector. A start in IDLE emits four single-cycle x pulses (arm, open,
// mid, close) separated by programmable low gaps.
//   clk, rst   : clock, synchronous active-high reset
//   start      : request a train (sampled only in IDLE)
//   gap_arm    : low cycles between arm and open pulses
//   len_a      : low cycles between open and mid pulses
//   len_b      : low cycles between mid and close pulses
//   abort      : cancel a train in progress (ignored in IDLE)
//   x_out      : registered serial pulse line
//   busy       : registered, high in every non-IDLE state
//   done       : one-cycle strobe in the IDLE cycle after a normal P_CLOSE
//   fsm_state  : current FSM state for observation
// Handshake: start is a request with no acknowledge; it is taken on any edge
// where the FSM sits in IDLE, including the cycle that done is high.
module q50_pulse_gen
    import q50_pkg::*;
#(
    parameter int W = Q50_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] gap_arm,
    input  logic [W-1:0] len_a,
    input  logic [W-1:0] len_b,
    input  logic         abort,
    output logic         x_out,
    output logic         busy,
    output logic         done,
    output logic [2:0]   fsm_state
);

    q50_gen_state_t state, state_n;

    logic [W-1:0] sh_gap_arm;
    logic [W-1:0] sh_len_a;
    logic [W-1:0] sh_len_b;

    logic         cnt_load;
    logic [W-1:0] cnt_val;
    logic         cnt_en;
    logic         cnt_last;

    // Pulses already emitted in this train; the close pulse must be the
    // last of Q50_PULSES for done to be raised.
    logic [2:0]   pulse_idx;

    q50_gap_counter #(.W(W)) u_gap_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .en       (cnt_en),
        .last     (cnt_last)
    );

    always_comb begin
        state_n  = state;
        cnt_load = 1'b0;
        cnt_val  = '0;
        cnt_en   = 1'b0;

        case (state)
            IDLE: begin
                if (start) state_n = P_ARM;
            end
            // A zero gap skips its G_* state so two pulses run back to back.
            P_ARM: begin
                if (sh_gap_arm == '0) begin
                    state_n = P_OPEN;
                end else begin
                    state_n  = G_ARM;
                    cnt_load = 1'b1;
                    cnt_val  = sh_gap_arm;
                end
            end
            G_ARM: begin
                cnt_en = 1'b1;
                if (cnt_last) state_n = P_OPEN;
            end
            P_OPEN: begin
                if (sh_len_a == '0) begin
                    state_n = P_MID;
                end else begin
                    state_n  = G_A;
                    cnt_load = 1'b1;
                    cnt_val  = sh_len_a;
                end
            end
            G_A: begin
                cnt_en = 1'b1;
                if (cnt_last) state_n = P_MID;
            end
            P_MID: begin
                if (sh_len_b == '0) begin
                    state_n = P_CLOSE;
                end else begin
                    state_n  = G_B;
                    cnt_load = 1'b1;
                    cnt_val  = sh_len_b;
                end
            end
            G_B: begin
                cnt_en = 1'b1;
                if (cnt_last) state_n = P_CLOSE;
            end
            P_CLOSE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Abort overrides every transition except acceptance from IDLE.
        if ((state != IDLE) && abort) begin
            state_n = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            x_out      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pulse_idx  <= '0;
            sh_gap_arm <= '0;
            sh_len_a   <= '0;
            sh_len_b   <= '0;
        end else begin
            state <= state_n;
            // Outputs are registered from the next state so they line up
            // with the state register, keeping x_out a pure Moore decode.
            x_out <= is_pulse_state(state_n);
            busy  <= (state_n != IDLE);
            done  <= (state == P_CLOSE) && !abort &&
                     (pulse_idx == 3'(Q50_PULSES - 1));

            if (state_n == IDLE) begin
                pulse_idx <= '0;
            end else begin
                pulse_idx <= pulse_idx + {2'b00, is_pulse_state(state)};
            end

            if ((state == IDLE) && start) begin
                sh_gap_arm <= gap_arm;
                sh_len_a   <= len_a;
                sh_len_b   <= len_b;
            end
        end
    end

    assign fsm_state = state;

endmodule

// File: tb/tb_q50_pulse_gen.sv
// Testbench for q50_pulse_gen: reset check, a table of per-cycle vectors
// covering the main train shapes and abort/reset corners, then hand-written
// sequences for the maximum arm gap and the train/window length arithmetic.
module tb_q50_pulse_gen;
    import q50_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] gap_arm;
    logic [W-1:0] len_a;
    logic [W-1:0] len_b;
    logic         abort;
    logic         x_out;
    logic         busy;
    logic         done;
    logic [2:0]   fsm_state;

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    q50_pulse_gen #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .gap_arm   (gap_arm),
        .len_a     (len_a),
        .len_b     (len_b),
        .abort     (abort),
        .x_out     (x_out),
        .busy      (busy),
        .done      (done),
        .fsm_state (fsm_state)
    );

    // ---------------- vector table ----------------
    // One record = inputs held for one cycle, then expected outputs in the
    // cycle after the next rising edge.
    typedef struct {
        logic         rst;
        logic         start;
        logic         abort;
        logic [W-1:0] ga;
        logic [W-1:0] la;
        logic [W-1:0] lb;
        logic         ex;
        logic         eb;
        logic         ed;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic s, input logic a,
                       input logic [W-1:0] ga, input logic [W-1:0] la,
                       input logic [W-1:0] lb,
                       input logic ex, input logic eb, input logic ed);
        vec_t v;
        v.rst = r; v.start = s; v.abort = a;
        v.ga = ga; v.la = la; v.lb = lb;
        v.ex = ex; v.eb = eb; v.ed = ed;
        vecs.push_back(v);
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic drive(input logic r, input logic s, input logic a,
                         input logic [W-1:0] ga, input logic [W-1:0] la,
                         input logic [W-1:0] lb);
        rst = r; start = s; abort = a;
        gap_arm = ga; len_a = la; len_b = lb;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_table();
        // A: gaps 2/3/1, pulses in cycles 1,4,8,10, done in 11.
        //    Inputs scrambled and start re-asserted mid-train.
        add(0,1,0, 2,3,1, 1,1,0);   // c1  P_ARM
        add(0,0,0, 9,9,9, 0,1,0);   // c2  G_ARM
        add(0,0,0, 9,9,9, 0,1,0);   // c3  G_ARM
        add(0,0,0, 9,9,9, 1,1,0);   // c4  P_OPEN
        add(0,1,0, 9,9,9, 0,1,0);   // c5  G_A
        add(0,0,0, 9,9,9, 0,1,0);   // c6  G_A
        add(0,0,0, 9,9,9, 0,1,0);   // c7  G_A
        add(0,0,0, 9,9,9, 1,1,0);   // c8  P_MID
        add(0,0,0, 9,9,9, 0,1,0);   // c9  G_B
        add(0,0,0, 9,9,9, 1,1,0);   // c10 P_CLOSE
        add(0,0,0, 9,9,9, 0,0,1);   // c11 done
        add(0,0,0, 9,9,9, 0,0,0);   // c12 idle
        // B: all gaps zero -> four consecutive highs, then done.
        add(0,1,0, 0,0,0, 1,1,0);
        add(0,0,0, 0,0,0, 1,1,0);
        add(0,0,0, 0,0,0, 1,1,0);
        add(0,0,0, 0,0,0, 1,1,0);
        add(0,0,0, 0,0,0, 0,0,1);
        add(0,0,0, 0,0,0, 0,0,0);
        // C: abort in the second G_A cycle, then a full restart.
        add(0,1,0, 1,3,1, 1,1,0);   // P_ARM
        add(0,0,0, 1,3,1, 0,1,0);   // G_ARM
        add(0,0,0, 1,3,1, 1,1,0);   // P_OPEN
        add(0,0,0, 1,3,1, 0,1,0);   // G_A #1
        add(0,0,0, 1,3,1, 0,1,0);   // G_A #2
        add(0,0,1, 1,3,1, 0,0,0);   // aborted
        add(0,0,0, 1,3,1, 0,0,0);
        add(0,0,0, 1,3,1, 0,0,0);
        add(0,1,0, 0,1,0, 1,1,0);   // P_ARM
        add(0,0,0, 0,1,0, 1,1,0);   // P_OPEN
        add(0,0,0, 0,1,0, 0,1,0);   // G_A
        add(0,0,0, 0,1,0, 1,1,0);   // P_MID
        add(0,0,0, 0,1,0, 1,1,0);   // P_CLOSE
        add(0,0,0, 0,1,0, 0,0,1);   // done
        add(0,0,0, 0,1,0, 0,0,0);
        // D: start held, gaps 1 -> back-to-back; second train's inputs
        //    changed to 4 after acceptance must not alter its spacing.
        for (int t = 0; t < 2; t++) begin
            add(0,1,0, 1,1,1, 1,1,0);
            add(0,1,0, 4*t[7:0]+8'(1-t),4*t[7:0]+8'(1-t),4*t[7:0]+8'(1-t), 0,1,0);
            add(0,1,0, (t==1)?8'd4:8'd1,(t==1)?8'd4:8'd1,(t==1)?8'd4:8'd1, 1,1,0);
            add(0,1,0, (t==1)?8'd4:8'd1,(t==1)?8'd4:8'd1,(t==1)?8'd4:8'd1, 0,1,0);
            add(0,1,0, (t==1)?8'd4:8'd1,(t==1)?8'd4:8'd1,(t==1)?8'd4:8'd1, 1,1,0);
            add(0,1,0, (t==1)?8'd4:8'd1,(t==1)?8'd4:8'd1,(t==1)?8'd4:8'd1, 0,1,0);
            add(0,1,0, (t==1)?8'd4:8'd1,(t==1)?8'd4:8'd1,(t==1)?8'd4:8'd1, 1,1,0);
            add(0,1,0, (t==1)?8'd4:8'd1,(t==1)?8'd4:8'd1,(t==1)?8'd4:8'd1, 0,0,1);
        end
        add(0,0,0, 4,4,4, 0,0,0);
        // E: start with abort in IDLE starts; abort during P_CLOSE wins.
        add(0,1,1, 0,0,0, 1,1,0);
        add(0,0,0, 0,0,0, 1,1,0);
        add(0,0,0, 0,0,0, 1,1,0);
        add(0,0,0, 0,0,0, 1,1,0);   // P_CLOSE
        add(0,0,1, 0,0,0, 0,0,0);   // no done
        add(0,0,0, 0,0,0, 0,0,0);
        // F: rst during P_MID with start high -> all zero, no new train.
        add(0,1,0, 0,0,0, 1,1,0);   // P_ARM
        add(0,0,0, 0,0,0, 1,1,0);   // P_OPEN
        add(0,0,0, 0,0,0, 1,1,0);   // P_MID
        add(1,1,0, 0,0,0, 0,0,0);
        add(0,0,0, 0,0,0, 0,0,0);
    endtask

    // ---------------- main test ----------------
    initial begin
        int low_cnt;
        int high_cnt;
        int busy_drop;
        int found;
        int cyc;
        int npulse;
        int p_idx[4];
        int done_idx;

        drive(1, 0, 0, 0, 0, 0);
        tick();
        tick();
        check("reset_x",     0, 32'(x_out), 0);
        check("reset_busy",  0, 32'(busy), 0);
        check("reset_done",  0, 32'(done), 0);
        check("reset_state", 0, 32'(fsm_state), 32'(IDLE));
        drive(0, 0, 0, 0, 0, 0);
        tick();

        fill_table();
        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].start, vecs[i].abort,
                  vecs[i].ga, vecs[i].la, vecs[i].lb);
            tick();
            check("vec_x",    i, 32'(x_out), 32'(vecs[i].ex));
            check("vec_busy", i, 32'(busy),  32'(vecs[i].eb));
            check("vec_done", i, 32'(done),  32'(vecs[i].ed));
        end
        drive(0, 0, 0, 0, 0, 0);
        tick();

        // Maximum arm gap: exactly 255 low cycles, busy held throughout.
        drive(0, 1, 0, 8'd255, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        check("max_arm_pulse", 0, 32'(x_out), 1);
        low_cnt = 0; busy_drop = 0; found = 0;
        for (int c = 0; c < 300; c++) begin
            tick();
            if (x_out) begin
                found = 1;
                break;
            end
            low_cnt++;
            if (!busy) busy_drop = 1;
        end
        check("max_gap_found", 0, 32'(found), 1);
        check("max_gap_len",   0, 32'(low_cnt), 255);
        check("max_gap_busy",  0, 32'(busy_drop), 0);
        high_cnt = (found != 0) ? 1 : 0;
        for (int c = 0; c < 6 && x_out; c++) begin
            tick();
            if (x_out) high_cnt++;
        end
        check("max_tail_highs", 0, 32'(high_cnt), 3);
        check("max_tail_done",  0, 32'(done), 1);
        tick();

        // Train and detector-window lengths for gaps 5/4/7.
        drive(0, 1, 0, 8'd5, 8'd4, 8'd7);
        npulse = 0; done_idx = -1; cyc = 0;
        for (int k = 0; k < 4; k++) p_idx[k] = 0;
        while (cyc < 60 && done_idx < 0) begin
            tick();
            drive(0, 0, 0, 0, 0, 0);
            cyc++;
            if (x_out) begin
                if (npulse < 4) p_idx[npulse] = cyc;
                npulse++;
            end
            if (done) done_idx = cyc;
        end
        check("len_done_seen", 0, 32'(done_idx >= 0), 1);
        check("len_pulses",    0, 32'(npulse), 32'(Q50_PULSES));
        check("len_train",     0, 32'(done_idx - 1), 32'(4 + 5 + 4 + 7));
        check("len_window",    0, 32'(p_idx[3] - p_idx[1]), 32'(2 + 4 + 7));
        tick();
        check("end_idle", 0, 32'(busy | x_out | done), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
